// File: rtl/steer_en.sv
// Rider-presence and steering-enable controller: weighs the two foot-pad load cells
// and enables steering only after the rider has stood balanced for the settling time.
module steer_en #(
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [7:0]  WT_HYSTERESIS = 8'h40,
    parameter bit          FAST_SIM      = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    typedef enum logic [1:0] {
        OFF      = 2'b00,
        WAIT     = 2'b01,
        STEER_EN = 2'b10
    } state_t;

    localparam logic [12:0] ENTER_WT = 13'(MIN_RIDER_WT) + 13'(WT_HYSTERESIS);
    localparam logic [12:0] LEAVE_WT = 13'(MIN_RIDER_WT) - 13'(WT_HYSTERESIS);

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [16:0] times15(input logic [12:0] v);
        logic [16:0] w;
        w = {4'b0000, v};
        return (w << 4) - w;
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [25:0] tmr;
    logic        tmr_clr;
    logic        tmr_inc;
    logic        tmr_full;

    logic [12:0] sum;
    logic [11:0] diff;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    assign sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign diff = abs_diff(lft_ld, rght_ld);

    assign sum_gt_min    = sum > ENTER_WT;
    assign sum_lt_min    = sum < LEAVE_WT;
    assign diff_gt_1_4   = {diff, 2'b00} > {1'b0, sum};
    // Imbalance ratio compared at 17 bits so 15*sum never wraps at full-scale loads.
    assign diff_gt_15_16 = {1'b0, diff, 4'b0000} > times15(sum);

    assign tmr_full = FAST_SIM ? (&tmr[14:0]) : (&tmr);

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        tmr_inc   = 1'b0;
        case (state)
            OFF: begin
                tmr_clr = 1'b1;
                if (sum_gt_min)
                    state_nxt = WAIT;
            end
            WAIT: begin
                if (sum_lt_min) begin
                    state_nxt = OFF;
                    tmr_clr   = 1'b1;
                end else if (diff_gt_1_4) begin
                    tmr_clr = 1'b1;
                end else if (tmr_full) begin
                    state_nxt = STEER_EN;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            STEER_EN: begin
                if (sum_lt_min) begin
                    state_nxt = OFF;
                    tmr_clr   = 1'b1;
                end else if (diff_gt_15_16) begin
                    state_nxt = WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = OFF;
                tmr_clr   = 1'b1;
            end
        endcase
    end

    // Outputs are registered alongside the state so they are exact decodes of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OFF;
            tmr       <= 26'd0;
            rider_off <= 1'b1;
            en_steer  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rider_off <= (state_nxt == OFF);
            en_steer  <= (state_nxt == STEER_EN);
            if (tmr_clr)
                tmr <= 26'd0;
            else if (tmr_inc)
                tmr <= tmr + 26'd1;
        end
    end

endmodule
